alu_sequencer: RTL and testbench

- Multi-cycle control unit that drives the 8-bit ALU's select inputs and consumes its carry/zero outputs.
- Fetches 8-bit instructions from a 32-word program memory through a request/valid handshake.
- Decodes each instruction into ALU_sel/load_shift plus an accumulator write strobe, latches the flags, and resolves jumps and conditional branches.
- Sits between program memory and the accumulator/ALU datapath of the microprocessor.

---
 rtl/alu_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the 8-bit ALU datapath: fetches instructions over a
// request/valid handshake, decodes ALU controls, latches flags and resolves jumps/branches.
module alu_sequencer #(
  parameter logic [4:0] RESET_PC = 5'd0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       fetch_req,
  output logic [4:0] pc_addr,
  input  logic [7:0] instr_data,
  input  logic       instr_valid,
  input  logic       alu_cout,
  input  logic       alu_zout,
  output logic [1:0] alu_sel,
  output logic [1:0] load_shift,
  output logic [7:0] imm,
  output logic       acc_we,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic       halt
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_NOR   = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_JC    = 3'd6;
  localparam logic [2:0] OP_JZ    = 3'd7;

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [4:0] pc_r;
  logic [4:0] pc_nxt_s;
  logic [4:0] pc_inc_s;
  logic [7:0] ir_r;
  logic       carry_r;
  logic       zero_r;
  logic       halt_r;
  logic       flags_we_s;
  logic [2:0] op_s;
  logic [4:0] tgt_s;

  assign op_s     = ir_r[7:5];
  assign tgt_s    = ir_r[4:0];
  assign pc_inc_s = pc_r + 5'd1;

  assign fetch_req  = (state_r == S_FETCH);
  assign pc_addr    = pc_r;
  assign imm        = {3'b000, ir_r[4:0]};
  assign carry_flag = carry_r;
  assign zero_flag  = zero_r;
  assign halt       = halt_r;

  // ALU control decode; the datapath only sees a live operation during EXEC
  always_comb begin
    alu_sel    = 2'b00;
    load_shift = 2'b00;
    acc_we     = 1'b0;
    if (state_r == S_EXEC) begin
      case (op_s)
        OP_ADD:   begin alu_sel = 2'b10; acc_we = 1'b1; end
        OP_SUB:   begin alu_sel = 2'b11; acc_we = 1'b1; end
        OP_NOR:   begin alu_sel = 2'b01; acc_we = 1'b1; end
        OP_SHIFT: begin alu_sel = 2'b00; load_shift = ir_r[1:0]; acc_we = 1'b1; end
        default:  begin alu_sel = 2'b00; end
      endcase
    end else begin
      alu_sel = 2'b00;
    end
  end

  // Next-state, next-PC and flag-update selection
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    flags_we_s  = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (instr_valid) begin
          state_nxt_s = S_EXEC;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_EXEC: begin
        state_nxt_s = S_FETCH;
        pc_nxt_s    = pc_inc_s;
        case (op_s)
          OP_ADD, OP_SUB, OP_NOR, OP_SHIFT: flags_we_s = 1'b1;
          OP_JMP: begin
            // A jump to itself is the program's way of stopping
            if (tgt_s == pc_r) begin
              state_nxt_s = S_HALT;
              pc_nxt_s    = pc_r;
            end else begin
              pc_nxt_s = tgt_s;
            end
          end
          OP_JC: begin
            if (carry_r) pc_nxt_s = tgt_s;
            else         pc_nxt_s = pc_inc_s;
          end
          OP_JZ: begin
            if (zero_r) pc_nxt_s = tgt_s;
            else        pc_nxt_s = pc_inc_s;
          end
          default: pc_nxt_s = pc_inc_s;
        endcase
      end
      S_HALT:  state_nxt_s = S_HALT;
      default: state_nxt_s = S_FETCH;
    endcase
  end

  // Architectural state; reset dominates any in-flight EXEC update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
      pc_r    <= RESET_PC;
      ir_r    <= 8'h00;
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
      halt_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      halt_r  <= (state_nxt_s == S_HALT);
      if ((state_r == S_FETCH) && instr_valid) begin
        ir_r <= instr_data;
      end
      if (flags_we_s) begin
        carry_r <= alu_cout;
        zero_r  <= alu_zout;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural model predicts each instruction's
// EXEC outputs and resulting PC/flags, queued at the fetch handshake and checked afterwards.
module tb_alu_sequencer;

  logic       clk;
  logic       reset;
  logic       fetch_req;
  logic [4:0] pc_addr;
  logic [7:0] instr_data;
  logic       instr_valid;
  logic       alu_cout;
  logic       alu_zout;
  logic [1:0] alu_sel;
  logic [1:0] load_shift;
  logic [7:0] imm;
  logic       acc_we;
  logic       carry_flag;
  logic       zero_flag;
  logic       halt;

  typedef struct packed {
    logic [1:0] sel;
    logic [1:0] ls;
    logic       we;
    logic [7:0] imm;
    logic [4:0] pc;
    logic       c;
    logic       z;
    logic       h;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [32];
  logic [4:0] m_pc;
  logic       m_c;
  logic       m_z;
  logic       m_h;
  int         checks = 0;
  int         errors = 0;

  alu_sequencer #(.RESET_PC(5'd0)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_addr(pc_addr),
    .instr_data(instr_data), .instr_valid(instr_valid), .alu_cout(alu_cout),
    .alu_zout(alu_zout), .alu_sel(alu_sel), .load_shift(load_shift), .imm(imm),
    .acc_we(acc_we), .carry_flag(carry_flag), .zero_flag(zero_flag), .halt(halt)
  );

  assign instr_data = mem[pc_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural prediction of one instruction from the architectural model state.
  function automatic exp_t predict(input logic [7:0] ins, input logic cout, input logic zout);
    exp_t e;
    logic [4:0] tgt;
    tgt   = ins[4:0];
    e.sel = 2'b00; e.ls = 2'b00; e.we = 1'b0;
    e.imm = {3'b000, ins[4:0]};
    e.pc  = m_pc + 5'd1; e.c = m_c; e.z = m_z; e.h = 1'b0;
    case (ins[7:5])
      3'd1: begin e.sel = 2'b10; e.we = 1'b1; e.c = cout; e.z = zout; end
      3'd2: begin e.sel = 2'b11; e.we = 1'b1; e.c = cout; e.z = zout; end
      3'd3: begin e.sel = 2'b01; e.we = 1'b1; e.c = cout; e.z = zout; end
      3'd4: begin e.ls = ins[1:0]; e.we = 1'b1; e.c = cout; e.z = zout; end
      3'd5: begin
        if (tgt == m_pc) begin e.pc = m_pc; e.h = 1'b1; end
        else e.pc = tgt;
      end
      3'd6: if (m_c) e.pc = tgt;
      3'd7: if (m_z) e.pc = tgt;
      default: e.pc = m_pc + 5'd1;
    endcase
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0; alu_cout = 1'b0; alu_zout = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_pc = 5'd0; m_c = 1'b0; m_z = 1'b0; m_h = 1'b0;
    check_val("rst_fetch_req", 8'(fetch_req), 8'(1'b1));
    check_val("rst_pc", 8'(pc_addr), 8'(5'd0));
    check_val("rst_carry", 8'(carry_flag), 8'(1'b0));
    check_val("rst_zero", 8'(zero_flag), 8'(1'b0));
    check_val("rst_halt", 8'(halt), 8'(1'b0));
    check_val("rst_acc_we", 8'(acc_we), 8'(1'b0));
    check_val("rst_alu_sel", 8'(alu_sel), 8'(2'b00));
    check_val("rst_load_shift", 8'(load_shift), 8'(2'b00));
    check_val("rst_imm", imm, 8'h00);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  // One instruction: optional stall, handshake, EXEC check, post-EXEC state check.
  task automatic run_instr(input int stall, input logic cout, input logic zout, input bit rst_exec);
    exp_t e;
    for (int i = 0; i < stall; i++) begin
      instr_valid = 1'b0;
      check_val("stall_fetch_req", 8'(fetch_req), 8'(1'b1));
      check_val("stall_pc", 8'(pc_addr), 8'(m_pc));
      check_val("stall_acc_we", 8'(acc_we), 8'(1'b0));
      @(negedge clk);
    end
    instr_valid = 1'b1; alu_cout = cout; alu_zout = zout;
    check_val("fetch_req", 8'(fetch_req), 8'(1'b1));
    check_val("fetch_pc", 8'(pc_addr), 8'(m_pc));
    exp_q.push_back(predict(mem[m_pc], cout, zout));
    @(negedge clk);
    e = exp_q.pop_front();
    check_val("exec_fetch_req", 8'(fetch_req), 8'(1'b0));
    check_val("exec_alu_sel", 8'(alu_sel), 8'(e.sel));
    check_val("exec_load_shift", 8'(load_shift), 8'(e.ls));
    check_val("exec_acc_we", 8'(acc_we), 8'(e.we));
    check_val("exec_imm", imm, e.imm);
    if (rst_exec) begin
      reset = 1'b1;
      e.pc = 5'd0; e.c = 1'b0; e.z = 1'b0; e.h = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0; instr_valid = 1'b0;
    m_pc = e.pc; m_c = e.c; m_z = e.z; m_h = e.h;
    check_val("post_pc", 8'(pc_addr), 8'(e.pc));
    check_val("post_carry", 8'(carry_flag), 8'(e.c));
    check_val("post_zero", 8'(zero_flag), 8'(e.z));
    check_val("post_halt", 8'(halt), 8'(e.h));
    check_val("post_fetch_req", 8'(fetch_req), 8'(!e.h));
    check_val("post_acc_we", 8'(acc_we), 8'(1'b0));
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; alu_cout = 1'b0; alu_zout = 1'b0;
    clear_mem();
    @(negedge clk);

    // ADD 5 then self-jump: halts with PC held at 1
    do_reset();
    mem[0] = 8'h25; mem[1] = 8'hA1;
    run_instr(0, 1'b0, 1'b0, 1'b0);
    run_instr(0, 1'b0, 1'b0, 1'b0);
    check_val("halt_after_jmp", 8'(halt), 8'(1'b1));
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1;
      @(negedge clk);
      check_val("halt_hold", 8'(halt), 8'(1'b1));
      check_val("halt_pc", 8'(pc_addr), 8'(5'd1));
      check_val("halt_fetch_req", 8'(fetch_req), 8'(1'b0));
      check_val("halt_acc_we", 8'(acc_we), 8'(1'b0));
      check_val("halt_alu_sel", 8'(alu_sel), 8'(2'b00));
    end

    // Reset out of HALT; stall, SUB/JC, shifts, NOR/JZ, wrap at 31
    do_reset();
    clear_mem();
    mem[2] = 8'h41; mem[3] = 8'hD0;
    mem[16] = 8'h83; mem[17] = 8'h81; mem[18] = 8'h82; mem[19] = 8'h80;
    mem[20] = 8'h7F; mem[21] = 8'hFE;
    run_instr(3, 1'b0, 1'b0, 1'b0);
    run_instr(0, 1'b1, 1'b1, 1'b0);
    check_val("nop_keeps_carry", 8'(carry_flag), 8'(1'b0));
    run_instr(0, 1'b1, 1'b0, 1'b0);
    check_val("sub_carry", 8'(carry_flag), 8'(1'b1));
    run_instr(0, 1'b0, 1'b0, 1'b0);
    check_val("jc_taken_pc", 8'(pc_addr), 8'(5'd16));
    run_instr(0, 1'b0, 1'b1, 1'b0);
    run_instr(0, 1'b1, 1'b0, 1'b0);
    run_instr(2, 1'b1, 1'b1, 1'b0);
    run_instr(0, 1'b0, 1'b0, 1'b0);
    run_instr(0, 1'b0, 1'b1, 1'b0);
    run_instr(0, 1'b0, 1'b0, 1'b0);
    check_val("jz_taken_pc", 8'(pc_addr), 8'(5'd30));
    run_instr(0, 1'b1, 1'b0, 1'b0);
    run_instr(0, 1'b1, 1'b0, 1'b0);
    check_val("wrap_pc", 8'(pc_addr), 8'(5'd0));
    check_val("nop_keeps_zero", 8'(zero_flag), 8'(1'b1));

    // JZ not taken after SUB with zero clear; taken JC to itself does not halt
    do_reset();
    clear_mem();
    mem[2] = 8'h41; mem[3] = 8'hF0; mem[4] = 8'hC4;
    run_instr(0, 1'b0, 1'b0, 1'b0);
    run_instr(0, 1'b0, 1'b0, 1'b0);
    run_instr(0, 1'b1, 1'b0, 1'b0);
    run_instr(0, 1'b0, 1'b1, 1'b0);
    check_val("jz_not_taken_pc", 8'(pc_addr), 8'(5'd4));
    run_instr(0, 1'b0, 1'b0, 1'b0);
    check_val("jc_self_pc", 8'(pc_addr), 8'(5'd4));
    check_val("jc_self_no_halt", 8'(halt), 8'(1'b0));

    // JMP 7 then reset during the ADD's EXEC
    do_reset();
    clear_mem();
    mem[0] = 8'hA7; mem[7] = 8'h23;
    run_instr(0, 1'b0, 1'b0, 1'b0);
    check_val("jmp_pc", 8'(pc_addr), 8'(5'd7));
    run_instr(0, 1'b1, 1'b1, 1'b1);
    check_val("midrst_pc", 8'(pc_addr), 8'(5'd0));
    check_val("midrst_carry", 8'(carry_flag), 8'(1'b0));
    check_val("midrst_fetch", 8'(fetch_req), 8'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
